// File: rtl/layer_feed_ctrl.sv
// rtl/layer_feed_ctrl.sv - LFSR top-row generator and load/start sequencer for the shift_layer stack
// Optional reachability filter on generated maps: define LAYER_PATH_CHECK_EN.
module layer_feed_ctrl #(
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter int          SCROLL_TICKS = 150,
  parameter int          MAX_TRIES    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        module_en,
  input  logic        one_ms_tick,
  input  logic        init_req,
  input  logic        scroll_req,
  output logic        start,
  output logic        load,
  output logic [0:6]  layer_map_out,
  output logic [0:6]  block_type_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] layer_count
);

  localparam logic [15:0]   SEED_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam int            TW        = (MAX_TRIES < 1) ? 1 : $clog2(MAX_TRIES + 1);
  localparam logic [7:0]    LAST_TICK = 8'(SCROLL_TICKS - 1);
  localparam logic [TW-1:0] TRY_LIMIT = TW'(MAX_TRIES);

  typedef enum logic [2:0] {IDLE, GEN, LOAD, START, WAIT, SETTLE, FIN} state_t;

  state_t        state;
  logic [15:0]   lfsr;
  logic [0:6]    prev_map;
  logic [7:0]    tick_cnt;
  logic [TW-1:0] tries;
  logic          settle_cnt;
  logic          scroll_mode;

  logic [0:6]    cand_map;
  logic [0:6]    cand_type;
  logic [0:6]    fb_type;
  logic [0:6]    commit_map;
  logic [0:6]    commit_type;
  logic          cand_ok;
  logic          commit;

  // Index i of the map is LFSR bit i, so the leftmost block comes from l[0].
  always_comb begin
    cand_map  = '0;
    cand_type = '0;
    fb_type   = '0;
    for (int i = 0; i < 7; i++) begin
      cand_map[i]  = lfsr[i];
      cand_type[i] = lfsr[7+i] & lfsr[i];
      fb_type[i]   = lfsr[7+i] & prev_map[i];
    end
  end

`ifdef LAYER_PATH_CHECK_EN
  assign cand_ok = (cand_map != '0) && ((cand_map & prev_map) != '0);
`else
  assign cand_ok = 1'b1;
`endif

  assign commit = cand_ok || (tries == TRY_LIMIT);

  always_comb begin
    commit_map  = cand_map;
    commit_type = cand_type;
`ifndef LAYER_PATH_CHECK_EN
    if (cand_map == '0) begin
      commit_map  = 7'b0001000;
      commit_type = '0;
    end
`endif
    // Out of tries: repeating the previous row always leaves a path open.
    if (!cand_ok) begin
      commit_map  = prev_map;
      commit_type = fb_type;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      lfsr           <= SEED_INIT;
      prev_map       <= '1;
      tick_cnt       <= '0;
      tries          <= '0;
      settle_cnt     <= 1'b0;
      scroll_mode    <= 1'b0;
      start          <= 1'b0;
      load           <= 1'b0;
      layer_map_out  <= '0;
      block_type_out <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      layer_count    <= '0;
    end else begin
      lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      start <= 1'b0;
      load  <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (module_en && (init_req || scroll_req)) begin
            scroll_mode <= !init_req;
            tries       <= '0;
            busy        <= 1'b1;
            state       <= GEN;
          end
        end
        GEN: begin
          if (commit) begin
            layer_map_out  <= commit_map;
            block_type_out <= commit_type;
            prev_map       <= commit_map;
            if (scroll_mode) begin
              start <= 1'b1;
              state <= START;
            end else begin
              load  <= 1'b1;
              state <= LOAD;
            end
          end else begin
            tries <= tries + 1'b1;
          end
        end
        LOAD: begin
          done  <= 1'b1;
          state <= FIN;
        end
        START: begin
          tick_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (one_ms_tick) begin
            if (tick_cnt == LAST_TICK) begin
              settle_cnt <= 1'b0;
              state      <= SETTLE;
            end else begin
              tick_cnt <= tick_cnt + 8'd1;
            end
          end
        end
        SETTLE: begin
          // Two cycles so the layers finish their end-of-scroll copy first.
          if (settle_cnt) begin
            done  <= 1'b1;
            state <= FIN;
            if (layer_count != 16'hFFFF) layer_count <= layer_count + 16'd1;
          end else begin
            settle_cnt <= 1'b1;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/layer_feed_ctrl.md
# layer_feed_ctrl

Upstream controller for the stack of `shift_layer` stages. It generates each new top-row block map and block-type pattern from a free-running 16-bit LFSR, and drives the shared `load` and `start` strobes. It then holds its outputs stable for the full 150-tick scroll, so every layer can latch the same data. It sits between game logic (`init_req`, `scroll_req`) and the top `shift_layer` instance (`POS_Y = 0`).

## Interface
Parameters:
- `SEED`, 16'hACE1: LFSR reset value; 16'h0000 is replaced by 16'h0001.
- `SCROLL_TICKS`, 150: number of `one_ms_tick` pulses in one scroll. Must equal the `shift_layer` scroll length.
- `MAX_TRIES`, 8: candidate maps rejected before fallback (only with path check compiled in).

Ports:
- `clk`  in  1  system/pixel clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `module_en`  in  1  requests are accepted only while high.
- `one_ms_tick`  in  1  one-cycle tick, shared with the `shift_layer` stages.
- `init_req`  in  1  pulse: generate a map and load it without scrolling.
- `scroll_req`  in  1  pulse: generate a map and scroll it in.
- `start`  out  1  one-cycle strobe to all `shift_layer` instances.
- `load`  out  1  one-cycle strobe to all `shift_layer` instances.
- `layer_map_out`  out  [0:6]  feeds `layer_map_in` of the top layer; bit 0 is the leftmost block.
- `block_type_out`  out  [0:6]  feeds `block_type_in`; always masked by `layer_map_out`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a sequence completes.
- `layer_count`  out  16  number of completed scrolls; saturates at 16'hFFFF.

## Operation
- LFSR:
  - Fibonacci, advances every cycle including during reset release.
  - Feedback `fb = l[15]^l[13]^l[12]^l[10]`; next value `{l[14:0], fb}`.
- Candidate map: `map[i] = l[i]` and `type[i] = l[7+i] & l[i]`, for i = 0..6.
- `prev_map` register: holds the last committed map; its reset value is 7'b1111111.
- FSM states:
  - IDLE:
    - `init_req & module_en` → GEN with mode=INIT.
    - Otherwise `scroll_req & module_en` → GEN with mode=SCROLL.
    - `init_req` wins if both are high.
    - Requests arriving while `busy` is high are dropped, not queued.
  - GEN: samples the candidate each cycle and commits an accepted candidate to `layer_map_out`, `block_type_out` and `prev_map`. A commit in INIT mode → LOAD; in SCROLL mode → START.
  - LOAD: `load` = 1 for one cycle → FIN.
  - START:
    - `start` = 1 for one cycle.
    - Clears the tick counter.
    - → WAIT.
  - WAIT: counts `one_ms_tick` pulses. On the `SCROLL_TICKS`-th tick → SETTLE.
  - SETTLE: lasts 2 cycles, covering the `shift_layer` END copy. Then → FIN, and `layer_count` increments.
  - FIN: `done` = 1 for one cycle → IDLE.
- `layer_map_out` and `block_type_out` change only on a GEN commit. They are stable from LOAD/START until the next GEN.
- `module_en` low after a request is accepted does not stall the FSM, because the `shift_layer` stages keep counting.

## Timing
- Reset values:
  - All outputs are 0.
  - State = IDLE, LFSR = `SEED`, `prev_map` = 7'b1111111.
  - Tick counter = 0, tries counter = 0.
- Reset asserted mid-sequence returns to IDLE on the next edge. No `done` pulse is issued.
- Request latency, without rejections:
  - Request at cycle 0, GEN commit at cycle 1.
  - `start` or `load` high at cycle 2.
- Scroll length:
  - `done` rises 3 cycles after the cycle carrying the final tick (SETTLE×2, then FIN).
  - A tick coinciding with the `start` cycle is not counted.
- Tick counter is 8 bits; `SCROLL_TICKS` must be ≤ 255.
- `layer_count` updates in the cycle `done` goes high.

## Configuration
- `LAYER_PATH_CHECK_EN` defined:
  - GEN accepts a candidate only if `map != 0` and `(map & prev_map) != 0`, which guarantees a reachable block.
  - Each rejected candidate costs one cycle.
  - After `MAX_TRIES` rejections, GEN commits `map = prev_map` and `type = l[13:7] & prev_map`.
- `LAYER_PATH_CHECK_EN` undefined:
  - GEN always commits in its first cycle.
  - A zero candidate map is replaced by 7'b0001000 with type 7'b0.

## Test plan
- Reset with `SEED` = 16'hACE1, then `init_req` at cycle 10:
  - `load` = 1 at cycle 12 only.
  - `start` stays 0.
  - `done` = 1 at cycle 13.
  - `layer_map_out` equals `l[6:0]` sampled at cycle 11; `block_type_out & ~layer_map_out` = 0.
- `scroll_req`, then 150 ticks spaced 100 cycles apart:
  - `start` pulses once.
  - Outputs stay constant throughout.
  - `done` comes 3 cycles after the 150th tick; `layer_count` = 1.
- `scroll_req` pulsed repeatedly during WAIT → ignored: one `start`, and `layer_count` increments by exactly 1.
- `init_req` and `scroll_req` in the same cycle → `load` pulses and `start` never pulses.
- `rst` asserted at tick 70 of a scroll:
  - Next cycle has `busy` = 0 and all outputs 0.
  - No `done` pulse.
  - A following `scroll_req` runs a full 150 ticks.
- With `LAYER_PATH_CHECK_EN`, force `prev_map` = 7'b1000000 and run 20 scrolls:
  - Every committed map overlaps the previous one.
  - GEN never exceeds `MAX_TRIES`+1 cycles.
  - With the macro undefined, no committed map is 0.
